// File: rtl/bp_nonsynth_commit_trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_commit_trace_arbiter
// Purpose  : Merges per-core commit records onto a single ready/valid trace
//            channel. Each core feeds a small circular buffer. A round-robin
//            arbiter drains the buffers into a registered output stage.
//            Cores are never stalled: a record that finds its buffer full is
//            dropped, flagged and counted. Per-core sequence numbers expose the
//            resulting gaps to the consumer.
// Ports    : clk_i, reset_n_i (sync, active-low), en_i (capture enable)
//            commit_*_i       per-core commit record, core 0 in the LSBs
//            trace_v_o / trace_yumi_i  output handshake (yumi only when valid)
//            trace_*_o        registered output record with core id and seq
//            overflow_o       sticky per-core drop flag
//            drop_cnt_o       saturating total drop count
// Revision : 1.0 - initial release
// ============================================================================
module bp_nonsynth_commit_trace_arbiter #(
  parameter int num_core_p    = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int els_p         = 4,
  parameter int seq_width_p   = 32,
  localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   en_i,
  input  logic [num_core_p-1:0]                  commit_v_i,
  input  logic [num_core_p*vaddr_width_p-1:0]    commit_pc_i,
  input  logic [num_core_p*instr_width_p-1:0]    commit_instr_i,
  input  logic [num_core_p-1:0]                  commit_rd_w_v_i,
  input  logic [num_core_p-1:0]                  commit_rd_fp_i,
  input  logic [num_core_p*5-1:0]                commit_rd_addr_i,
  input  logic [num_core_p*dword_width_p-1:0]    commit_rd_data_i,
  output logic                                   trace_v_o,
  input  logic                                   trace_yumi_i,
  output logic [core_id_width_lp-1:0]            trace_core_o,
  output logic [seq_width_p-1:0]                 trace_seq_o,
  output logic [vaddr_width_p-1:0]               trace_pc_o,
  output logic [instr_width_p-1:0]               trace_instr_o,
  output logic                                   trace_rd_w_v_o,
  output logic                                   trace_rd_fp_o,
  output logic [4:0]                             trace_rd_addr_o,
  output logic [dword_width_p-1:0]               trace_rd_data_o,
  output logic [num_core_p-1:0]                  overflow_o,
  output logic [15:0]                            drop_cnt_o
);

  localparam int ptr_width_lp  = $clog2(els_p);
  localparam int cnt_width_lp  = ptr_width_lp + 1;
  localparam int cand_width_lp = core_id_width_lp + 1;
  // Stored record: {seq, pc, instr, rd_w_v, rd_fp, rd_addr, rd_data}
  localparam int rec_width_lp  = seq_width_p + vaddr_width_p + instr_width_p + 7 + dword_width_p;
  localparam logic [cnt_width_lp-1:0]     full_cnt_lp  = cnt_width_lp'(els_p);
  localparam logic [core_id_width_lp-1:0] last_core_lp = core_id_width_lp'(num_core_p - 1);

  logic [ptr_width_lp-1:0]      head_q  [num_core_p];
  logic [ptr_width_lp-1:0]      head_d  [num_core_p];
  logic [ptr_width_lp-1:0]      tail_q  [num_core_p];
  logic [ptr_width_lp-1:0]      tail_d  [num_core_p];
  logic [cnt_width_lp-1:0]      count_q [num_core_p];
  logic [cnt_width_lp-1:0]      count_d [num_core_p];
  logic [seq_width_p-1:0]       seq_q   [num_core_p];
  logic [seq_width_p-1:0]       seq_d   [num_core_p];
  logic [core_id_width_lp-1:0]  rr_ptr_q, rr_ptr_d;
  logic                         trace_v_q, trace_v_d;
  logic [core_id_width_lp-1:0]  trace_core_q, trace_core_d;
  logic [rec_width_lp-1:0]      trace_rec_q, trace_rec_d;
  logic [num_core_p-1:0]        overflow_q, overflow_d;
  logic [15:0]                  drop_cnt_q, drop_cnt_d;

  logic [num_core_p*rec_width_lp-1:0] wr_rec_flat;
  logic [num_core_p*rec_width_lp-1:0] head_rec_flat;
  logic [num_core_p-1:0]        capture, enq, deq, drop;
  logic                         load, grant_v;
  logic [core_id_width_lp-1:0]  grant_id;
  logic [cand_width_lp-1:0]     cand;
  logic [rec_width_lp-1:0]      grant_rec;
  logic [16:0]                  drop_sum;

  // Per-core record storage; the record is stamped with the core's current seq.
  for (genvar c = 0; c < num_core_p; c++) begin : g_core
    logic [rec_width_lp-1:0] mem_q [els_p];
    logic [rec_width_lp-1:0] mem_d [els_p];

    assign wr_rec_flat[c*rec_width_lp +: rec_width_lp] =
      {seq_q[c],
       commit_pc_i[c*vaddr_width_p +: vaddr_width_p],
       commit_instr_i[c*instr_width_p +: instr_width_p],
       commit_rd_w_v_i[c],
       commit_rd_fp_i[c],
       commit_rd_addr_i[c*5 +: 5],
       commit_rd_data_i[c*dword_width_p +: dword_width_p]};

    always_comb begin
      mem_d = mem_q;
      if (enq[c]) mem_d[tail_q[c]] = wr_rec_flat[c*rec_width_lp +: rec_width_lp];
    end

    always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
    end

    assign head_rec_flat[c*rec_width_lp +: rec_width_lp] = mem_q[head_q[c]];
  end

  always_comb begin
    load     = ~trace_v_q | trace_yumi_i;
    grant_v  = 1'b0;
    grant_id = '0;
    cand     = '0;
    // Cyclic search starting at rr_ptr; rr_ptr + i never reaches 2*num_core_p,
    // so a single conditional subtract performs the wrap.
    for (int i = 0; i < num_core_p; i++) begin
      cand = {1'b0, rr_ptr_q} + cand_width_lp'(i);
      if (cand >= cand_width_lp'(num_core_p)) cand = cand - cand_width_lp'(num_core_p);
      if (load && !grant_v && (count_q[cand[core_id_width_lp-1:0]] != '0)) begin
        grant_v  = 1'b1;
        grant_id = cand[core_id_width_lp-1:0];
      end
    end

    grant_rec = '0;
    for (int c = 0; c < num_core_p; c++) begin
      if (grant_v && (grant_id == core_id_width_lp'(c)))
        grant_rec = head_rec_flat[c*rec_width_lp +: rec_width_lp];
    end

    // Fullness is judged on the start-of-cycle count; a same-cycle pop of the
    // same buffer frees the slot the incoming record needs.
    drop_sum = {1'b0, drop_cnt_q};
    for (int c = 0; c < num_core_p; c++) begin
      capture[c]    = commit_v_i[c] & en_i;
      deq[c]        = grant_v && (grant_id == core_id_width_lp'(c));
      enq[c]        = capture[c] && ((count_q[c] != full_cnt_lp) || deq[c]);
      drop[c]       = capture[c] && (count_q[c] == full_cnt_lp) && !deq[c];
      head_d[c]     = head_q[c] + ptr_width_lp'(deq[c]);
      tail_d[c]     = tail_q[c] + ptr_width_lp'(enq[c]);
      count_d[c]    = count_q[c] + cnt_width_lp'(enq[c]) - cnt_width_lp'(deq[c]);
      seq_d[c]      = seq_q[c] + seq_width_p'(capture[c]);
      overflow_d[c] = overflow_q[c] | drop[c];
      drop_sum      = drop_sum + 17'(drop[c]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    rr_ptr_d     = rr_ptr_q;
    trace_v_d    = trace_v_q;
    trace_core_d = trace_core_q;
    trace_rec_d  = trace_rec_q;
    if (grant_v) begin
      trace_v_d    = 1'b1;
      trace_core_d = grant_id;
      trace_rec_d  = grant_rec;
      rr_ptr_d     = (grant_id == last_core_lp) ? '0 : grant_id + core_id_width_lp'(1);
    end else if (load) begin
      trace_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_core_p; c++) begin
        head_q[c]  <= '0;
        tail_q[c]  <= '0;
        count_q[c] <= '0;
        seq_q[c]   <= '0;
      end
      rr_ptr_q     <= '0;
      trace_v_q    <= 1'b0;
      trace_core_q <= '0;
      trace_rec_q  <= '0;
      overflow_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      for (int c = 0; c < num_core_p; c++) begin
        head_q[c]  <= head_d[c];
        tail_q[c]  <= tail_d[c];
        count_q[c] <= count_d[c];
        seq_q[c]   <= seq_d[c];
      end
      rr_ptr_q     <= rr_ptr_d;
      trace_v_q    <= trace_v_d;
      trace_core_q <= trace_core_d;
      trace_rec_q  <= trace_rec_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign trace_v_o    = trace_v_q;
  assign trace_core_o = trace_core_q;
  assign {trace_seq_o, trace_pc_o, trace_instr_o, trace_rd_w_v_o,
          trace_rd_fp_o, trace_rd_addr_o, trace_rd_data_o} = trace_rec_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_commit_trace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_nonsynth_commit_trace_arbiter
// Purpose  : Self-checking bench for bp_nonsynth_commit_trace_arbiter:
//            vector table, directed corner sequences and random stimulus
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_nonsynth_commit_trace_arbiter;
  localparam int NC  = 2;
  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int DW  = 64;
  localparam int ELS = 4;
  localparam int SW  = 32;
  localparam int CW  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, en, yumi;
  logic [NC-1:0]     commit_v, rd_w_v, rd_fp;
  logic [NC*VW-1:0]  commit_pc;
  logic [NC*IW-1:0]  commit_instr;
  logic [NC*5-1:0]   rd_addr;
  logic [NC*DW-1:0]  rd_data;

  logic              trace_v_o, trace_rd_w_v_o, trace_rd_fp_o;
  logic [CW-1:0]     trace_core_o;
  logic [SW-1:0]     trace_seq_o;
  logic [VW-1:0]     trace_pc_o;
  logic [IW-1:0]     trace_instr_o;
  logic [4:0]        trace_rd_addr_o;
  logic [DW-1:0]     trace_rd_data_o;
  logic [NC-1:0]     overflow_o;
  logic [15:0]       drop_cnt_o;

  bp_nonsynth_commit_trace_arbiter #(
    .num_core_p(NC), .vaddr_width_p(VW), .instr_width_p(IW),
    .dword_width_p(DW), .els_p(ELS), .seq_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .commit_v_i(commit_v), .commit_pc_i(commit_pc), .commit_instr_i(commit_instr),
    .commit_rd_w_v_i(rd_w_v), .commit_rd_fp_i(rd_fp),
    .commit_rd_addr_i(rd_addr), .commit_rd_data_i(rd_data),
    .trace_v_o(trace_v_o), .trace_yumi_i(yumi), .trace_core_o(trace_core_o),
    .trace_seq_o(trace_seq_o), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_rd_w_v_o(trace_rd_w_v_o), .trace_rd_fp_o(trace_rd_fp_o),
    .trace_rd_addr_o(trace_rd_addr_o), .trace_rd_data_o(trace_rd_data_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: per-core queues + one output slot -------
  typedef struct packed {
    logic [SW-1:0] seq;
    logic [VW-1:0] pc;
    logic [IW-1:0] instr;
    logic          w;
    logic          fp;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } rec_t;

  rec_t          mq [NC][$];
  logic          m_v;
  int            m_core;
  rec_t          m_out;
  int            m_rr;
  logic [SW-1:0] m_seq [NC];
  logic [NC-1:0] m_ovf;
  int            m_drop;

  function automatic void model_step();
    int  g;
    bit  ld;
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        m_seq[c] = '0;
      end
      m_v = 1'b0; m_core = 0; m_out = '0; m_rr = 0; m_ovf = '0; m_drop = 0;
      return;
    end
    ld = !m_v || yumi;
    g  = -1;
    if (ld) begin
      for (int i = 0; i < NC; i++) begin
        int c = (m_rr + i) % NC;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    end
    if (g >= 0) begin
      m_out  = mq[g].pop_front();
      m_core = g;
      m_v    = 1'b1;
      m_rr   = (g + 1) % NC;
    end else if (ld) begin
      m_v = 1'b0;
    end
    if (en) begin
      for (int c = 0; c < NC; c++) begin
        if (commit_v[c]) begin
          rec_t r;
          r.seq   = m_seq[c];
          r.pc    = commit_pc[c*VW +: VW];
          r.instr = commit_instr[c*IW +: IW];
          r.w     = rd_w_v[c];
          r.fp    = rd_fp[c];
          r.addr  = rd_addr[c*5 +: 5];
          r.data  = rd_data[c*DW +: DW];
          m_seq[c] = m_seq[c] + 1'b1;
          if (mq[c].size() < ELS) mq[c].push_back(r);
          else begin
            m_ovf[c] = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
    end
  endfunction

  // One clock: advance the model with the applied inputs, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_v", trace_v_o, m_v);
    chk("model_ovf", overflow_o, m_ovf);
    chk("model_drop", drop_cnt_o, 16'(m_drop));
    if (m_v)
      chk("model_rec",
          {trace_core_o, trace_seq_o, trace_pc_o, trace_instr_o, trace_rd_w_v_o,
           trace_rd_fp_o, trace_rd_addr_o, trace_rd_data_o},
          {CW'(m_core), m_out});
  endtask

  task automatic set_core(int c, logic [VW-1:0] p, logic [IW-1:0] ins, logic w,
                          logic fp, logic [4:0] a, logic [DW-1:0] d);
    commit_pc[c*VW +: VW]    = p;
    commit_instr[c*IW +: IW] = ins;
    rd_w_v[c]                = w;
    rd_fp[c]                 = fp;
    rd_addr[c*5 +: 5]        = a;
    rd_data[c*DW +: DW]      = d;
  endtask

  task automatic rand_core(int c);
    set_core(c, VW'({$urandom, $urandom}), $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b1; commit_v = '0; yumi = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ---------------------------------------------
  typedef struct {
    logic          rst_n;
    logic          en;
    logic [1:0]    cv;
    logic          yumi;
    logic [VW-1:0] pc;
    logic [IW-1:0] instr;
    logic          exp_v;
    logic          exp_core;
    logic [SW-1:0] exp_seq;
    logic [VW-1:0] exp_pc;
    logic [1:0]    exp_ovf;
    logic [15:0]   exp_drop;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [1:0] c, logic y, logic [VW-1:0] p,
                              logic [IW-1:0] ins, logic ev, logic ec, logic [SW-1:0] es,
                              logic [VW-1:0] ep, logic [1:0] eo, logic [15:0] ed);
    vec_t v;
    v.rst_n = r; v.en = e; v.cv = c; v.yumi = y; v.pc = p; v.instr = ins;
    v.exp_v = ev; v.exp_core = ec; v.exp_seq = es; v.exp_pc = ep;
    v.exp_ovf = eo; v.exp_drop = ed;
    return v;
  endfunction

  vec_t          tbl [20];
  logic [SW-1:0] got_seq [$];
  logic          got_core [$];
  bit            found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // rows: rst_n en cv yumi pc instr | v core seq pc ovf drop
    tbl[0]  = mk(0, 1, 2'b00, 0, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[1]  = mk(0, 1, 2'b00, 0, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[2]  = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[3]  = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[4]  = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[5]  = mk(1, 1, 2'b01, 1, 39'h80000000, 32'h13, 0, 0, 0, 39'h0,    2'b00, 0);
    tbl[6]  = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  1, 0, 0, 39'h80000000, 2'b00, 0);
    tbl[7]  = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b00, 0);
    tbl[8]  = mk(1, 1, 2'b10, 0, 39'h1000,     32'h20, 0, 0, 0, 39'h0,    2'b00, 0);
    tbl[9]  = mk(1, 1, 2'b10, 0, 39'h1010,     32'h21, 1, 1, 0, 39'h1004, 2'b00, 0);
    tbl[10] = mk(1, 1, 2'b10, 0, 39'h1020,     32'h22, 1, 1, 0, 39'h1004, 2'b00, 0);
    tbl[11] = mk(1, 1, 2'b10, 0, 39'h1030,     32'h23, 1, 1, 0, 39'h1004, 2'b00, 0);
    tbl[12] = mk(1, 1, 2'b10, 0, 39'h1040,     32'h24, 1, 1, 0, 39'h1004, 2'b00, 0);
    tbl[13] = mk(1, 1, 2'b10, 0, 39'h1050,     32'h25, 1, 1, 0, 39'h1004, 2'b10, 1);
    tbl[14] = mk(1, 1, 2'b10, 0, 39'h1060,     32'h26, 1, 1, 0, 39'h1004, 2'b10, 2);
    tbl[15] = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  1, 1, 1, 39'h1014, 2'b10, 2);
    tbl[16] = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  1, 1, 2, 39'h1024, 2'b10, 2);
    tbl[17] = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  1, 1, 3, 39'h1034, 2'b10, 2);
    tbl[18] = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  1, 1, 4, 39'h1044, 2'b10, 2);
    tbl[19] = mk(1, 1, 2'b00, 1, 39'h0,        32'h0,  0, 0, 0, 39'h0,    2'b10, 2);

    reset_n = 1'b0; en = 1'b1; commit_v = '0; yumi = 1'b0;
    commit_pc = '0; commit_instr = '0; rd_w_v = '0; rd_fp = '0; rd_addr = '0; rd_data = '0;

    for (int i = 0; i < 20; i++) begin
      reset_n  = tbl[i].rst_n;
      en       = tbl[i].en;
      commit_v = tbl[i].cv;
      yumi     = tbl[i].yumi;
      for (int c = 0; c < NC; c++)
        set_core(c, tbl[i].pc + VW'(4 * c), tbl[i].instr + IW'(c), 1'b0, 1'b0, 5'd0, '0);
      cycle();
      chk($sformatf("tbl%0d_v", i), trace_v_o, tbl[i].exp_v);
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl%0d_core", i), trace_core_o, tbl[i].exp_core);
        chk($sformatf("tbl%0d_seq", i), trace_seq_o, tbl[i].exp_seq);
        chk($sformatf("tbl%0d_pc", i), trace_pc_o, tbl[i].exp_pc);
      end
      chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_drop", i), drop_cnt_o, tbl[i].exp_drop);
    end

    // Both cores commit every cycle for 6 cycles, consumer always ready.
    do_reset();
    yumi = 1'b1;
    got_seq.delete();
    got_core.delete();
    for (int k = 0; k < 16; k++) begin
      commit_v = (k < 6) ? 2'b11 : 2'b00;
      rand_core(0);
      rand_core(1);
      cycle();
      if (trace_v_o) begin
        got_seq.push_back(trace_seq_o);
        got_core.push_back(trace_core_o[0]);
      end
    end
    chk("alt_count", got_seq.size(), 12);
    for (int j = 0; j < got_seq.size() && j < 12; j++) begin
      chk($sformatf("alt%0d_core", j), got_core[j], j % 2);
      chk($sformatf("alt%0d_seq", j), got_seq[j], j / 2);
    end
    chk("alt_ovf", overflow_o, 0);

    // Full buffer, consumer ready: commit and grant of core 0 in one cycle.
    do_reset();
    yumi = 1'b0;
    commit_v = 2'b01;
    for (int k = 0; k < 5; k++) begin
      rand_core(0);
      cycle();
    end
    chk("full_pre_v", trace_v_o, 1);
    chk("full_pre_seq", trace_seq_o, 0);
    yumi = 1'b1;
    rand_core(0);
    cycle();
    chk("full_grant_seq", trace_seq_o, 1);
    chk("full_grant_drop", drop_cnt_o, 0);
    chk("full_grant_ovf", overflow_o, 0);
    commit_v = 2'b00;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk($sformatf("full_tail%0d_v", j), trace_v_o, 1);
      chk($sformatf("full_tail%0d_seq", j), trace_seq_o, 2 + j);
    end
    cycle();
    chk("full_empty_v", trace_v_o, 0);

    // Capture disabled while commits are strobed.
    en = 1'b0;
    yumi = 1'b0;
    commit_v = 2'b01;
    for (int k = 0; k < 3; k++) begin
      rand_core(0);
      cycle();
      chk($sformatf("en_off%0d_v", k), trace_v_o, 0);
    end
    en = 1'b1;
    rand_core(0);
    cycle();
    commit_v = 2'b00;
    yumi = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (trace_v_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("en_found", found, 1);
    if (found) begin
      chk("en_seq", trace_seq_o, 6);
      chk("en_core", trace_core_o, 0);
    end
    cycle();

    // Reset in the middle of traffic.
    yumi = 1'b0;
    commit_v = 2'b10;
    for (int k = 0; k < 6; k++) begin
      rand_core(1);
      cycle();
    end
    chk("rst_pre_v", trace_v_o, 1);
    chk("rst_pre_ovf", overflow_o, 2'b10);
    chk("rst_pre_drop", drop_cnt_o, 1);
    reset_n = 1'b0;
    commit_v = 2'b00;
    cycle();
    reset_n = 1'b1;
    chk("rst_v", trace_v_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    commit_v = 2'b10;
    yumi = 1'b1;
    rand_core(1);
    cycle();
    commit_v = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (trace_v_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_found", found, 1);
    if (found) begin
      chk("rst_seq", trace_seq_o, 0);
      chk("rst_core", trace_core_o, 1);
    end
    cycle();
    chk("rst_nothing_left", trace_v_o, 0);

    // Random traffic against the model, slow consumer then fast consumer.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_n  = ($urandom_range(0, 499) != 0);
      en       = ($urandom_range(0, 9) != 0);
      commit_v = 2'($urandom);
      rand_core(0);
      rand_core(1);
      yumi = trace_v_o & ($urandom_range(0, 99) < ((n < 1500) ? 30 : 85));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
